icache_refill: RTL

//  Line-refill writer for the L1 instruction cache. On an icache miss it captures the

---
 rtl/icache_refill.sv | 131 +++++++++++++
 1 files changed

// File: rtl/icache_refill.sv
// icache_refill: L1 instruction cache line refill writer.
// Fetches a line word by word over req/gnt/rvalid and writes the icache.
module icache_refill #(
  parameter int ADDR_SIZE  = 32,
  parameter int ISA_SIZE   = 32,
  parameter int LINE_WORDS = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 miss_i,
  input  logic [ADDR_SIZE-1:0] miss_pc_i,
  input  logic                 flush_i,
  output logic                 mem_req_o,
  output logic [ADDR_SIZE-1:0] mem_addr_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [ISA_SIZE-1:0]  mem_rdata_i,
  output logic                 ic_we_o,
  output logic [ADDR_SIZE-1:0] ic_addr_o,
  output logic [ISA_SIZE-1:0]  ic_inst_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int CW = $clog2(LINE_WORDS);
  localparam logic [ADDR_SIZE-1:0] OFF_MASK =
    ADDR_SIZE'(LINE_WORDS * 4 - 1);
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, WRITE, DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ADDR_SIZE-1:0] base_q, base_d;
  logic [ISA_SIZE-1:0]  data_q, data_d;
  logic                 abort_q, abort_d;
  logic [ADDR_SIZE-1:0] word_addr;

  assign word_addr = base_q + (ADDR_SIZE'(cnt_q) << 2);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      data_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      data_q  <= data_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    data_d     = data_q;
    abort_d    = abort_q;
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
    ic_we_o    = 1'b0;
    ic_addr_o  = '0;
    ic_inst_o  = '0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (miss_i && !flush_i) begin
          base_d  = miss_pc_i & ~OFF_MASK;
          cnt_d   = '0;
          abort_d = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        busy_o     = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = word_addr;
        // a granted request must still be drained even when flushed
        if (mem_gnt_i) begin
          abort_d = flush_i;
          state_d = WAIT;
        end else if (flush_i) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        busy_o = 1'b1;
        if (mem_rvalid_i) begin
          if (abort_q || flush_i) begin
            abort_d = 1'b0;
            state_d = IDLE;
          end else begin
            data_d  = mem_rdata_i;
            state_d = WRITE;
          end
        end else if (flush_i) begin
          abort_d = 1'b1;
        end
      end
      WRITE: begin
        busy_o    = 1'b1;
        ic_addr_o = word_addr;
        ic_inst_o = data_q;
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          ic_we_o = 1'b1;
          if (cnt_q == LAST) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = REQ;
          end
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
